// File: rtl/prom_loader_if.sv
// Byte-stream and RAM port-B signal bundle for the boot loader.
// master = stream source / RAM side, slave = loader.
interface prom_loader_if #(
  parameter int unsigned ADDR_BITS = 15
) ();
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 ram_en;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [7:0]           ram_din;

  modport master (
    output in_data, in_valid,
    input  in_ready,
    input  ram_en, ram_we, ram_addr, ram_din
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready,
    output ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/prom_loader.sv
// Framed byte-stream boot loader: writes payload into program RAM port B,
// verifies an 8-bit modulo checksum and holds the CPU off while loading.
module prom_loader #(
  parameter int unsigned ADDR_BITS      = 15,
  parameter int unsigned MEM_BYTES      = 20480,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  prom_loader_if.slave bus,
  output logic        cpu_hold,
  output logic        done,
  output logic        err_csum,
  output logic        err_range,
  output logic        err_timeout
);

  // One bit wider than the 16-bit pointer so start+length can never wrap to 0.
  localparam int unsigned PW = 17;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_A_HI, S_A_LO, S_L_HI, S_L_LO, S_DATA, S_CSUM, S_REPORT
  } state_t;

  state_t               r_state, w_next;
  logic [7:0]           r_addr_hi, r_len_hi, r_sum;
  logic [PW-1:0]        r_ptr;
  logic [15:0]          r_cnt;
  logic [TW-1:0]        r_tmo;
  logic                 r_hold, r_done;
  logic                 r_err_csum, r_err_range, r_err_timeout;
  logic                 r_ram_en;
  logic [ADDR_BITS-1:0] r_ram_addr;
  logic [7:0]           r_ram_din;

  logic                 w_ready, w_acc, w_in_frame, w_tmo_hit;
  logic [7:0]           w_sum_nxt;
  logic [15:0]          w_hdr, w_len;
  logic [PW-1:0]        w_start;

  assign w_ready    = !rst && (r_state != S_REPORT);
  assign w_acc      = bus.in_valid && w_ready;
  assign w_in_frame = (r_state != S_IDLE) && (r_state != S_REPORT);
  assign w_tmo_hit  = w_in_frame && !w_acc && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_sum_nxt  = r_sum + bus.in_data;
  assign w_hdr      = {r_addr_hi, bus.in_data};
  assign w_len      = {r_len_hi, bus.in_data};
  assign w_start    = PW'(w_hdr[ADDR_BITS-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_acc && bus.in_data == SYNC_BYTE) w_next = S_A_HI;
      S_A_HI:   if (w_acc) w_next = S_A_LO;
      S_A_LO:   if (w_acc) w_next = S_L_HI;
      S_L_HI:   if (w_acc) w_next = S_L_LO;
      S_L_LO:   if (w_acc) w_next = (w_len == '0) ? S_CSUM : S_DATA;
      S_DATA:   if (w_acc && r_cnt == 16'd1) w_next = S_CSUM;
      S_CSUM:   if (w_acc) w_next = S_REPORT;
      S_REPORT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_tmo_hit) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_hi     <= '0;
      r_len_hi      <= '0;
      r_sum         <= '0;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_tmo         <= '0;
      r_hold        <= 1'b0;
      r_done        <= 1'b0;
      r_err_csum    <= 1'b0;
      r_err_range   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_ram_en      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_din     <= '0;
    end else begin
      r_ram_en <= 1'b0;
      r_done   <= 1'b0;
      if (w_acc || !w_in_frame) r_tmo <= '0;
      else                      r_tmo <= r_tmo + 1'b1;
      if (w_acc && w_in_frame) r_sum <= w_sum_nxt;

      unique case (r_state)
        S_IDLE: if (w_acc && bus.in_data == SYNC_BYTE) begin
          r_sum         <= '0;
          r_hold        <= 1'b1;
          r_err_csum    <= 1'b0;
          r_err_range   <= 1'b0;
          r_err_timeout <= 1'b0;
        end
        S_A_HI: if (w_acc) r_addr_hi <= bus.in_data;
        S_A_LO: if (w_acc) r_ptr <= w_start;
        S_L_HI: if (w_acc) r_len_hi <= bus.in_data;
        S_L_LO: if (w_acc) r_cnt <= w_len;
        S_DATA: if (w_acc) begin
          if (r_ptr < PW'(MEM_BYTES)) begin
            r_ram_en   <= 1'b1;
            r_ram_addr <= r_ptr[ADDR_BITS-1:0];
            r_ram_din  <= bus.in_data;
          end else begin
            r_err_range <= 1'b1;
          end
          r_ptr <= r_ptr + 1'b1;
          r_cnt <= r_cnt - 1'b1;
        end
        // done is registered off the CSUM byte so it is high during REPORT.
        S_CSUM: if (w_acc) r_done <= (w_sum_nxt == 8'h00) && !r_err_range && !r_err_timeout;
        S_REPORT: begin
          if (r_sum != 8'h00) r_err_csum <= 1'b1;
          r_hold <= 1'b0;
        end
        default: ;
      endcase

      if (w_tmo_hit) begin
        r_err_timeout <= 1'b1;
        r_hold        <= 1'b0;
      end
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.ram_en   = r_ram_en;
  assign bus.ram_we   = r_ram_en;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_din  = r_ram_din;
  assign cpu_hold     = r_hold;
  assign done         = r_done;
  assign err_csum     = r_err_csum;
  assign err_range    = r_err_range;
  assign err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_prom_loader.sv
// Self-checking bench for prom_loader: scoreboard of expected RAM writes
// plus per-scenario checks of handshake, hold, done and error flags.
module tb_prom_loader;
  localparam int unsigned AB   = 15;
  localparam int unsigned MEMB = 20480;
  localparam int unsigned TMO  = 16;

  logic clk = 1'b0;
  logic rst;
  logic cpu_hold, done, err_csum, err_range, err_timeout;

  always #5 clk = ~clk;

  prom_loader_if #(.ADDR_BITS(AB)) bus ();

  prom_loader #(
    .ADDR_BITS(AB), .MEM_BYTES(MEMB), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cpu_hold(cpu_hold), .done(done), .err_csum(err_csum),
    .err_range(err_range), .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp    = 0;
  int  n_bad    = 0;
  int  done_cnt = 0;

  // Write monitor: every RAM write must match the oldest expected one.
  always @(negedge clk) begin
    wr_t e;
    if (done) done_cnt++;
    if (bus.ram_en) begin
      n_cmp++;
      if (bus.ram_we !== 1'b1) begin
        n_bad++;
        $display("FAIL ram_we_with_en actual=%b required=1", bus.ram_we);
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write actual addr=%h data=%h required=none",
                 bus.ram_addr, bus.ram_din);
      end else begin
        e = exp_q.pop_front();
        if ({bus.ram_addr, bus.ram_din} !== e) begin
          n_bad++;
          $display("FAIL write actual addr=%h data=%h required addr=%h data=%h",
                   bus.ram_addr, bus.ram_din, e.addr, e.data);
        end
      end
    end
  end

  // Frame checksum: two's complement of the sum of every byte after SYNC.
  function automatic logic [7:0] csum8(input logic [15:0] a, input logic [15:0] len,
                                       input logic [7:0] base, input logic [7:0] step);
    logic [7:0] s;
    s = a[15:8] + a[7:0] + len[15:8] + len[7:0];
    for (int unsigned i = 0; i < len; i++) s = s + base + 8'(step * i);
    return 8'h00 - s;
  endfunction

  // Presents one byte (caller at a negedge) and returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.in_ready; i++) @(negedge clk);
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_bound byte=%h actual=not_ready required=ready", b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends a complete frame; returns in the REPORT cycle with in_valid low.
  task automatic send_frame(input logic [15:0] a, input logic [15:0] len,
                            input logic [7:0] base, input logic [7:0] step,
                            input logic [7:0] cs_delta);
    logic [16:0] p;
    logic [7:0]  b;
    send_byte(8'hA5);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    p = {2'b00, a[AB-1:0]};
    for (int unsigned i = 0; i < len; i++) begin
      b = base + 8'(step * i);
      if (p < 17'(MEMB)) exp_q.push_back({p[AB-1:0], b});
      send_byte(b);
      p = p + 1'b1;
    end
    send_byte(csum8(a, len, base, step) + cs_delta);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #2;
    n_cmp++;
    if ({bus.in_ready, bus.ram_en, bus.ram_we, cpu_hold, done, err_csum, err_range, err_timeout} !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_outputs actual=%b required=00000000",
               {bus.in_ready, bus.ram_en, bus.ram_we, cpu_hold, done, err_csum, err_range, err_timeout});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset actual=%b required=1", bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    int d0;
    d0 = done_cnt;
    n_cmp++;
    if (cpu_hold !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_before_sync actual=%b required=0", cpu_hold);
    end
    send_byte(8'hA5);
    n_cmp++;
    if (cpu_hold !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_after_sync actual=%b required=1", cpu_hold);
    end
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h03);
    exp_q.push_back({15'h0010, 8'h11});
    exp_q.push_back({15'h0011, 8'h22});
    exp_q.push_back({15'h0012, 8'h33});
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    n_cmp++;
    if ({bus.ram_en, cpu_hold} !== 2'b11) begin
      n_bad++;
      $display("FAIL last_write_under_hold actual=%b required=11", {bus.ram_en, cpu_hold});
    end
    send_byte(8'h87);
    bus.in_valid = 1'b0;
    n_cmp++;
    if ({done, cpu_hold, bus.in_ready} !== 3'b110) begin
      n_bad++;
      $display("FAIL report_cycle actual=%b required=110", {done, cpu_hold, bus.in_ready});
    end
    @(negedge clk);
    n_cmp++;
    if ({done, cpu_hold, err_csum, err_range, err_timeout} !== 5'b0) begin
      n_bad++;
      $display("FAIL after_report actual=%b required=00000",
               {done, cpu_hold, err_csum, err_range, err_timeout});
    end
    n_cmp++;
    if (done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL good_done_count actual=%0d pending=%0d required=1/0", done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    int d0;
    d0 = done_cnt;
    send_frame(16'h1234, 16'd0, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (done_cnt - d0 !== 1 || err_csum !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_len actual done=%0d csum_err=%b required done=1 csum_err=0", done_cnt - d0, err_csum);
    end
  endtask

  task automatic test_range();
    int d0;
    d0 = done_cnt;
    send_frame(16'h4FFE, 16'd4, 8'h5A, 8'h01, 8'h00);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({err_range, err_csum} !== 2'b10 || done_cnt - d0 !== 0 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL range actual range=%b csum=%b done=%0d pending=%0d required 1/0/0/0",
               err_range, err_csum, done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_bad_csum();
    int d0;
    d0 = done_cnt;
    send_frame(16'h0010, 16'd3, 8'h11, 8'h11, 8'h01);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({err_csum, err_range} !== 2'b10 || done_cnt - d0 !== 0 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL bad_csum actual csum=%b range=%b done=%0d pending=%0d required 1/0/0/0",
               err_csum, err_range, done_cnt - d0, exp_q.size());
    end
    send_frame(16'h0100, 16'd2, 8'hC3, 8'h3C, 8'h00);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (err_csum !== 1'b0 || done_cnt - d0 !== 1) begin
      n_bad++;
      $display("FAIL csum_clear actual csum=%b done=%0d required 0/1", err_csum, done_cnt - d0);
    end
  endtask

  task automatic test_timeout();
    int d0;
    d0 = done_cnt;
    send_byte(8'hA5);
    send_byte(8'h00);
    bus.in_valid = 1'b0;
    repeat (TMO - 1) @(negedge clk);
    n_cmp++;
    if ({err_timeout, cpu_hold} !== 2'b01) begin
      n_bad++;
      $display("FAIL timeout_early actual=%b required=01", {err_timeout, cpu_hold});
    end
    @(negedge clk);
    n_cmp++;
    if ({err_timeout, cpu_hold, bus.in_ready} !== 3'b101 || done_cnt - d0 !== 0) begin
      n_bad++;
      $display("FAIL timeout_abort actual=%b done=%0d required=101 done=0",
               {err_timeout, cpu_hold, bus.in_ready}, done_cnt - d0);
    end
    send_frame(16'h0200, 16'd3, 8'h01, 8'h02, 8'h00);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (err_timeout !== 1'b0 || done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL timeout_recover actual tmo=%b done=%0d pending=%0d required 0/1/0",
               err_timeout, done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h04);
    exp_q.push_back({15'h0020, 8'hD1});
    exp_q.push_back({15'h0021, 8'hD2});
    send_byte(8'hD1);
    send_byte(8'hD2);
    bus.in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.ram_en, bus.ram_we, cpu_hold, done} !== 5'b0 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL reset_mid actual=%b pending=%0d required=00000/0",
               {bus.in_ready, bus.ram_en, bus.ram_we, cpu_hold, done}, exp_q.size());
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_byte(8'h00);
    send_byte(8'hFF);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cpu_hold, bus.in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL noise_discard actual=%b required=01", {cpu_hold, bus.in_ready});
    end
    d0 = done_cnt;
    send_frame(16'h0030, 16'd2, 8'h77, 8'h11, 8'h00);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL reset_recover actual done=%0d pending=%0d required 1/0", done_cnt - d0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_zero_len();
    test_range();
    test_bad_csum();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end
endmodule
